pipe_sub_32bit: RTL and testbench
=================================

Name: pipe_sub_32bit

Overview:
- 32-bit two-stage pipelined subtractor computing diff = a - b - borrow_in, with borrow_out and status flags.
- It is the subtract-direction counterpart to the team's 32-bit split adder. The low 16-bit half is resolved in stage 1 and the high half in stage 2, with the inter-half borrow registered between stages.
- Valid/ready handshake on both sides. It sits in the ALU datapath between operand fetch and writeback.

Parameters:
- WIDTH, 32, total operand width. Must be even; split point is WIDTH/2.
- HALF, WIDTH/2, width of each pipeline half. Derived; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands presented
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- borrow_in  input  1  borrow into bit 0
- out_valid  output  1  result presented
- out_ready  input  1  downstream accepts result
- diff  output  WIDTH  a - b - borrow_in, mod 2^WIDTH
- borrow_out  output  1  1 when unsigned a < b + borrow_in
- zero  output  1  diff == 0
- overflow  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB]

Behaviour:
- Reset (rst=1 at posedge):
  - s1_valid, s2_valid clear to 0, so out_valid=0.
  - diff, borrow_out, zero, overflow reset to 0.
  - in_ready reads 1 in the cycle after reset deasserts.
- Stage 1 registers, loaded on in_valid && in_ready:
  - lo_diff = a[HALF-1:0] - b[HALF-1:0] - borrow_in
  - mid_borrow = borrow of that operation
  - a_hi, b_hi = upper halves of a and b
  - s1_valid <= 1
- Stage 2 registers, loaded when s1_valid && s2 advance:
  - diff = {a_hi - b_hi - mid_borrow, lo_diff}
  - borrow_out = borrow of the high half
  - zero and overflow computed from the full registered result
  - s2_valid <= 1
- Advance conditions:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational from out_ready; no skid buffer)
- A stage whose upstream is not valid clears its valid bit when it advances.
- Latency: exactly 2 cycles from accepted input to out_valid with no backpressure. Throughput is 1 per cycle.
- Output hold: while out_valid && !out_ready, all outputs stay stable and stage 1 holds if valid. Both stages full gives in_ready=0.
- Simultaneous events:
  - out_ready with s1_valid and in_valid in the same cycle: all three transfers happen, and the pipeline stays full.
- Wrap-around:
  - 0 - 1 gives diff=0xFFFFFFFF, borrow_out=1.
  - borrow_in=1 with a==b gives 0xFFFFFFFF, borrow_out=1.
- Reset mid-operation: in-flight results are discarded, with no output pulse after reset. Inputs with in_valid during rst are ignored.
- Outputs are registered only; no combinational path from a/b to any output. in_ready is the only combinational output, and it depends only on out_ready and state.
- Payload while out_valid=0 holds the last value; downstream must qualify it with out_valid.

Decomposition:
- Shared package (alu_pkg): ALU_WIDTH=32, ALU_HALF=16, and a flag struct/typedef {zero, overflow, borrow} reused by the adder side.
- One sub-module, sub_16bit: combinational a - b - borrow_in giving diff and borrow_out.
  - Instantiated twice, once per stage, to mirror the adder's half-split structure.
- Handshake/valid logic stays in the top.

Test Plan:
- After reset, a=0x00000005, b=0x00000003, borrow_in=0, single beat, out_ready=1 → two cycles later: diff=0x00000002, borrow_out=0, zero=0, overflow=0, out_valid high for 1 cycle.
- a=0x00010000, b=0x00000001 (borrow crosses the half boundary) → diff=0x0000FFFF, borrow_out=0; a=0, b=1 → diff=0xFFFFFFFF, borrow_out=1.
- a=0x80000000, b=0x00000001 → diff=0x7FFFFFFF, overflow=1, borrow_out=0; a=b=0x12345678, borrow_in=0 → diff=0, zero=1.
- Back-to-back beats on 3 consecutive cycles, with out_ready low for cycles 2-4:
  - in_ready drops once both stages are full.
  - Outputs stay stable while stalled.
  - All 3 results emerge in order with no loss or duplication.
- Assert rst while two beats are in flight → out_valid=0 next cycle and stays 0; the next post-reset beat is the only output seen.
- Random 10k beats with random in_valid/out_ready → scoreboard matches (a - b - borrow_in) mod 2^32 and reference flags.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths and the status-flag bundle used by
// both the split adder and the split subtractor.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned ALU_HALF  = ALU_WIDTH / 2;

    // Status flags produced alongside an arithmetic result.
    typedef struct packed {
        logic zero;
        logic overflow;
        logic borrow;
    } alu_flags_t;

    // Signed overflow of a subtraction: operands differ in sign and the result
    // sign does not follow the minuend.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                          input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/sub_16bit.sv
// Combinational half-width subtractor: diff = a - b - borrow, with borrow out.
module sub_16bit
    import alu_pkg::*;
#(
    parameter int unsigned W = ALU_HALF
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         borrow_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    // One extra bit catches the borrow: a negative result wraps and sets bit W.
    logic [W:0] ext;

    // Zero-extended subtraction; the top bit is the borrow out of the half.
    always_comb begin
        ext = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, borrow_i};
    end

    assign diff_o   = ext[W-1:0];
    assign borrow_o = ext[W];

endmodule

// File: rtl/pipe_sub_32bit.sv
// Two-stage pipelined subtractor. Stage 1 resolves the low half and registers
// the inter-half borrow; stage 2 resolves the high half and the status flags.
// Valid/ready on both sides, no skid buffer: in_ready follows out_ready
// combinationally through the stage-advance chain.
module pipe_sub_32bit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned HALF = WIDTH / 2;

    // Handshake
    logic s1_adv;
    logic s2_adv;
    logic in_fire;

    // Stage 1 state
    logic            s1_valid_q, s1_valid_d;
    logic [HALF-1:0] s1_lo_diff_q, s1_lo_diff_d;
    logic            s1_mid_borrow_q, s1_mid_borrow_d;
    logic [HALF-1:0] s1_a_hi_q, s1_a_hi_d;
    logic [HALF-1:0] s1_b_hi_q, s1_b_hi_d;

    // Stage 2 state (drives the outputs directly)
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    alu_flags_t       flags_q, flags_d;

    // Half-subtractor results
    logic [HALF-1:0]  lo_diff;
    logic             lo_borrow;
    logic [HALF-1:0]  hi_diff;
    logic             hi_borrow;
    logic [WIDTH-1:0] full_diff;

    // Low half straight from the input operands.
    sub_16bit #(
        .W (HALF)
    ) u_sub_lo (
        .a_i      (a[HALF-1:0]),
        .b_i      (b[HALF-1:0]),
        .borrow_i (borrow_in),
        .diff_o   (lo_diff),
        .borrow_o (lo_borrow)
    );

    // High half from the stage-1 registers and the registered mid borrow.
    sub_16bit #(
        .W (HALF)
    ) u_sub_hi (
        .a_i      (s1_a_hi_q),
        .b_i      (s1_b_hi_q),
        .borrow_i (s1_mid_borrow_q),
        .diff_o   (hi_diff),
        .borrow_o (hi_borrow)
    );

    assign full_diff = {hi_diff, s1_lo_diff_q};

    // Advance chain: a stage moves when it is empty or its consumer moves.
    always_comb begin
        s2_adv  = !s2_valid_q || out_ready;
        s1_adv  = !s1_valid_q || s2_adv;
        in_fire = in_valid && s1_adv;
    end

    assign in_ready = s1_adv;

    // Stage 1 next state: capture low-half result and upper operand halves.
    always_comb begin
        s1_valid_d      = s1_valid_q;
        s1_lo_diff_d    = s1_lo_diff_q;
        s1_mid_borrow_d = s1_mid_borrow_q;
        s1_a_hi_d       = s1_a_hi_q;
        s1_b_hi_d       = s1_b_hi_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            s1_lo_diff_d    = lo_diff;
            s1_mid_borrow_d = lo_borrow;
            s1_a_hi_d       = a[WIDTH-1:HALF];
            s1_b_hi_d       = b[WIDTH-1:HALF];
        end
    end

    // Stage 2 next state: payload only reloads on a real transfer, so it holds
    // its last value while out_valid is low.
    always_comb begin
        s2_valid_d = s2_valid_q;
        diff_d     = diff_q;
        flags_d    = flags_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                diff_d           = full_diff;
                flags_d.borrow   = hi_borrow;
                flags_d.zero     = (full_diff == '0);
                flags_d.overflow = sub_overflow(s1_a_hi_q[HALF-1], s1_b_hi_q[HALF-1],
                                                hi_diff[HALF-1]);
            end
        end
    end

    // Stage 1 registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q      <= 1'b0;
            s1_lo_diff_q    <= '0;
            s1_mid_borrow_q <= 1'b0;
            s1_a_hi_q       <= '0;
            s1_b_hi_q       <= '0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_lo_diff_q    <= s1_lo_diff_d;
            s1_mid_borrow_q <= s1_mid_borrow_d;
            s1_a_hi_q       <= s1_a_hi_d;
            s1_b_hi_q       <= s1_b_hi_d;
        end
    end

    // Stage 2 (output) registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            flags_q    <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            diff_q     <= diff_d;
            flags_q    <= flags_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign diff       = diff_q;
    assign borrow_out = flags_q.borrow;
    assign zero       = flags_q.zero;
    assign overflow   = flags_q.overflow;

endmodule

// File: tb/tb_pipe_sub_32bit.sv
// Scoreboard bench for pipe_sub_32bit: the driver pushes expected results on
// each accepted beat, an independent monitor pops and compares on each output
// transfer.
module tb_pipe_sub_32bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        borrow_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow_out;
    logic        zero;
    logic        overflow;

    typedef struct {
        logic [31:0] d;
        logic        bw;
        logic        z;
        logic        ov;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_in   = 0;
    int   n_out  = 0;
    bit   rand_ready = 1'b0;

    pipe_sub_32bit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] d, input logic bw, input logic z,
                                input logic ov);
        exp_t e;
        e.d  = d;
        e.bw = bw;
        e.z  = z;
        e.ov = ov;
        return e;
    endfunction

    // Reference: full-width subtraction with one extra bit for the borrow.
    function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb,
                                   input logic tbin);
        logic [32:0] r;
        exp_t        e;
        r    = {1'b0, ta} - {1'b0, tb} - {32'd0, tbin};
        e.d  = r[31:0];
        e.bw = r[32];
        e.z  = (r[31:0] == 32'd0);
        e.ov = (ta[31] != tb[31]) && (r[31] != ta[31]);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one beat and hold it until accepted; expected result is queued.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tbin,
                        input exp_t e);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        borrow_in = tbin;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready) begin
            sb_q.push_back(e);
            n_in++;
        end else begin
            checks++;
            errors++;
            in_valid = 1'b0;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, sb_q.size(), 0);
    endtask

    // Monitor: compare every output transfer against the scoreboard head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got diff=0x%08h with empty scoreboard", diff);
            end else begin
                e = sb_q.pop_front();
                n_out++;
                if (diff !== e.d || borrow_out !== e.bw || zero !== e.z || overflow !== e.ov)
                begin
                    errors++;
                    $display("FAIL result #%0d: got diff=0x%08h bw=%b z=%b ov=%b expected diff=0x%08h bw=%b z=%b ov=%b",
                             n_out, diff, borrow_out, zero, overflow, e.d, e.bw, e.z, e.ov);
                end
            end
        end
    end

    // Random backpressure for the soak phase.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] va   [9];
        logic [31:0] vb   [9];
        logic        vbin [9];
        logic [31:0] vd   [9];
        logic        vbw  [9];
        logic        vz   [9];
        logic        vov  [9];
        int          base;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rbin;

        // Directed vectors with hand-computed results.
        va   = '{32'h0001_0000, 32'h0000_0000, 32'h8000_0000, 32'h1234_5678, 32'h1234_5678,
                 32'h7FFF_FFFF, 32'hFFFF_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        vb   = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h1234_5678, 32'h1234_5678,
                 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vbin = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vd   = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF,
                 32'h8000_0000, 32'hFFFE_0000, 32'h0000_0000, 32'hFFFF_FFFD};
        vbw  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vz   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vov  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow_out", borrow_out, 0);
        check("rst_zero", zero, 0);
        check("rst_overflow", overflow, 0);
        check("rst_in_ready", in_ready, 1);

        // Single beat: two-cycle latency, one-cycle valid pulse.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = 32'd5;
        b        = 32'd3;
        @(negedge clk);
        check("lat_in_ready", in_ready, 1);
        sb_q.push_back(mk(32'd2, 1'b0, 1'b0, 1'b0));
        n_in++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1_out_valid", out_valid, 0);
        @(negedge clk);
        check("lat_cycle2_out_valid", out_valid, 1);
        @(negedge clk);
        check("lat_pulse_end", out_valid, 0);

        // Directed vectors back to back.
        for (int i = 0; i < 9; i++) begin
            send(va[i], vb[i], vbin[i], mk(vd[i], vbw[i], vz[i], vov[i]));
        end
        idle();
        drain("directed_drain");

        // Three consecutive beats with out_ready low on cycles 2-4.
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 32'd100;
        b         = 32'd1;
        borrow_in = 1'b0;
        @(negedge clk);
        check("stall_c1_in_ready", in_ready, 1);
        sb_q.push_back(mk(32'd99, 1'b0, 1'b0, 1'b0));
        n_in++;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        a         = 32'h0000_0010;
        b         = 32'h0000_0020;
        @(negedge clk);
        check("stall_c2_in_ready", in_ready, 1);
        sb_q.push_back(mk(32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0));
        n_in++;
        @(posedge clk);
        #1;
        a         = 32'hABCD_0000;
        b         = 32'h0000_ABCD;
        borrow_in = 1'b1;
        @(negedge clk);
        check("stall_c3_in_ready", in_ready, 0);
        check("stall_c3_out_valid", out_valid, 1);
        check("stall_c3_diff", diff, 32'd99);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("stall_c4_in_ready", in_ready, 0);
        check("stall_c4_diff", diff, 32'd99);
        check("stall_c4_borrow_out", borrow_out, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_c5_in_ready", in_ready, 1);
        sb_q.push_back(mk(32'hABCC_5432, 1'b0, 1'b0, 1'b0));
        n_in++;
        idle();
        borrow_in = 1'b0;
        drain("stall_drain");

        // Reset with two beats in flight; the input during reset is ignored.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 32'd7;
        b         = 32'd2;
        @(negedge clk);
        check("rstmid_accept1", in_ready, 1);
        @(posedge clk);
        #1;
        a = 32'd9;
        b = 32'd4;
        @(negedge clk);
        check("rstmid_accept2", in_ready, 1);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        a         = 32'd50;
        b         = 32'd8;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstmid_out_valid", out_valid, 0);
        end
        check("rstmid_diff", diff, 0);
        base = n_out;
        send(32'h0000_0020, 32'h0000_0001, 1'b0, mk(32'h0000_001F, 1'b0, 1'b0, 1'b0));
        idle();
        drain("rstmid_drain");
        repeat (3) @(negedge clk);
        check("rstmid_single_output", n_out - base, 1);

        // Random soak with random bubbles and backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            ra   = $urandom;
            rb   = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            rbin = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) idle();
            send(ra, rb, rbin, model(ra, rb, rbin));
        end
        idle();
        drain("random_drain");
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("final_queue_empty", sb_q.size(), 0);
        check("final_in_out_count", n_out, n_in);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
